l2_cache: RTL



---
 rtl/l2_cache_pkg.sv | 26 ++
 rtl/l2_cache_if.sv | 32 +++
 rtl/l2_victim_select.sv | 32 +++
 rtl/l2_cache.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and field-width helpers for the L2 cache.
// Holds the controller state enum, a helper that derives the index width
// from the cache geometry, and the field widths for the default geometry
// (4 KiB, 16-byte lines, 4 ways, 32-bit addresses).
package l2_cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCompareTag,
    StWriteBack,
    StAllocate,
    StRespond
  } state_e;

  function automatic int unsigned index_width(input int unsigned cache_size,
                                              input int unsigned block_size,
                                              input int unsigned num_ways);
    return $clog2(cache_size / block_size / num_ways);
  endfunction

  localparam int unsigned OFFSET_WIDTH = $clog2(16);
  localparam int unsigned INDEX_WIDTH  = index_width(4096, 16, 4);
  localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WAY_WIDTH    = $clog2(4);

endpackage

// File: rtl/l2_cache_if.sv
// l2_cache_if: L1-side request bus and memory-side handshake bus of the L2.
// Modports:
//   master - driven by the L1 client and the memory (requests, fill data, mem_ready)
//   slave  - the cache (responses, memory address/data/strobes)
interface l2_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [DATA_WIDTH-1:0] l1_data_in;
  logic                  l1_read;
  logic                  l1_write;
  logic [DATA_WIDTH-1:0] l1_data_out;
  logic                  l1_ready;
  logic                  l1_hit;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_ready;

  modport master (
    output l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    input  l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );

  modport slave (
    input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    output l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_victim_select.sv
// l2_victim_select: combinational replacement choice for one set.
// Ports:
//   valid_i   - per-way valid bits of the set
//   ptr_i     - the set's round-robin pointer
//   victim_o  - way to replace
//   advance_o - set when the pointer was used and must advance
// The lowest-numbered invalid way wins; only a full set falls back to the pointer.
module l2_victim_select #(
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned WayW    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WayW-1:0]     ptr_i,
  output logic [WayW-1:0]     victim_o,
  output logic                advance_o
);

  logic found;

  always_comb begin
    found    = 1'b0;
    victim_o = ptr_i;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        found    = 1'b1;
        victim_o = WayW'(w);
      end
    end
    advance_o = !found;
  end

endmodule

// File: rtl/l2_cache.sv
// l2_cache: 4-way set-associative, write-back, write-allocate L2 cache.
// One data word per line. Misses evict a dirty victim to memory before the fill.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   cache_io - slave side of l2_cache_if (L1 request/response + memory handshake)
// All outputs are registered; valid/dirty bits and pointers reset, tag/data do not.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CACHE_SIZE = 4096,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned NUM_WAYS   = 4
) (
  input logic        clk,
  input logic        rst,
  l2_cache_if.slave  cache_io
);

  localparam int unsigned OffW    = $clog2(BLOCK_SIZE);
  localparam int unsigned NumSets = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int unsigned IdxW    = index_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int unsigned TagW    = ADDR_WIDTH - IdxW - OffW;
  localparam int unsigned WayW    = $clog2(NUM_WAYS);

  // Storage
  logic [TagW-1:0]       tag_q   [NumSets][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q  [NumSets][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q [NumSets];
  logic [NUM_WAYS-1:0]   dirty_q [NumSets];
  logic [WayW-1:0]       ptr_q   [NumSets];

  // Controller state and latched request
  state_e                state_q;
  logic [TagW-1:0]       req_tag_q;
  logic [IdxW-1:0]       req_idx_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic                  req_write_q;
  logic [WayW-1:0]       victim_q;

  // Registered outputs
  logic [DATA_WIDTH-1:0] l1_data_out_q;
  logic                  l1_ready_q;
  logic                  l1_hit_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_out_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  // Offset bits select a byte within the one-word line and are not used.
  logic unused_offset;
  assign unused_offset = ^cache_io.l1_addr[OffW-1:0];

  // Tag lookup in the latched set
  logic            hit;
  logic [WayW-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx_q][w] && tag_q[req_idx_q][w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  logic [WayW-1:0] vs_victim;
  logic            vs_advance;

  l2_victim_select #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_select (
    .valid_i   (valid_q[req_idx_q]),
    .ptr_i     (ptr_q[req_idx_q]),
    .victim_o  (vs_victim),
    .advance_o (vs_advance)
  );

  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [ADDR_WIDTH-1:0] wb_addr;
  assign fill_addr = {req_tag_q, req_idx_q, {OffW{1'b0}}};
  assign wb_addr   = {tag_q[req_idx_q][vs_victim], req_idx_q, {OffW{1'b0}}};

  logic fill_done;
  assign fill_done = (state_q == StAllocate) && mem_read_q && cache_io.mem_ready;

  // Tag/data array write port: write hits and completed fills.
  logic                  arr_data_we;
  logic                  arr_tag_we;
  logic [WayW-1:0]       arr_way;
  logic [DATA_WIDTH-1:0] arr_wdata;

  always_comb begin
    arr_data_we = 1'b0;
    arr_tag_we  = 1'b0;
    arr_way     = hit_way;
    arr_wdata   = req_wdata_q;
    if (state_q == StCompareTag && hit && req_write_q) begin
      arr_data_we = 1'b1;
    end else if (fill_done) begin
      arr_data_we = 1'b1;
      arr_tag_we  = 1'b1;
      arr_way     = victim_q;
      arr_wdata   = req_write_q ? req_wdata_q : cache_io.mem_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_data_we) data_q[req_idx_q][arr_way] <= arr_wdata;
    if (arr_tag_we)  tag_q[req_idx_q][arr_way]  <= req_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      req_tag_q      <= '0;
      req_idx_q      <= '0;
      req_wdata_q    <= '0;
      req_write_q    <= 1'b0;
      victim_q       <= '0;
      l1_data_out_q  <= '0;
      l1_ready_q     <= 1'b0;
      l1_hit_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      for (int unsigned s = 0; s < NumSets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          l1_ready_q  <= 1'b0;
          l1_hit_q    <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (cache_io.l1_read || cache_io.l1_write) begin
            req_tag_q   <= cache_io.l1_addr[ADDR_WIDTH-1 -: TagW];
            req_idx_q   <= cache_io.l1_addr[OffW +: IdxW];
            req_wdata_q <= cache_io.l1_data_in;
            req_write_q <= cache_io.l1_write;  // write wins when both are high
            state_q     <= StCompareTag;
          end
        end
        StCompareTag: begin
          if (hit) begin
            if (req_write_q) dirty_q[req_idx_q][hit_way] <= 1'b1;
            else             l1_data_out_q <= data_q[req_idx_q][hit_way];
            l1_hit_q   <= 1'b1;
            l1_ready_q <= 1'b1;
            state_q    <= StRespond;
          end else begin
            victim_q <= vs_victim;
            if (vs_advance) ptr_q[req_idx_q] <= ptr_q[req_idx_q] + WayW'(1);
            if (valid_q[req_idx_q][vs_victim] && dirty_q[req_idx_q][vs_victim]) begin
              mem_addr_q     <= wb_addr;
              mem_data_out_q <= data_q[req_idx_q][vs_victim];
              mem_write_q    <= 1'b1;
              state_q        <= StWriteBack;
            end else begin
              mem_addr_q <= fill_addr;
              mem_read_q <= 1'b1;
              state_q    <= StAllocate;
            end
          end
        end
        StWriteBack: begin
          if (mem_write_q && cache_io.mem_ready) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= fill_addr;
            mem_read_q  <= 1'b1;
            state_q     <= StAllocate;
          end
        end
        StAllocate: begin
          if (fill_done) begin
            mem_read_q                   <= 1'b0;
            valid_q[req_idx_q][victim_q] <= 1'b1;
            dirty_q[req_idx_q][victim_q] <= req_write_q;
            if (!req_write_q) l1_data_out_q <= cache_io.mem_data_in;
            l1_hit_q   <= 1'b0;
            l1_ready_q <= 1'b1;
            state_q    <= StRespond;
          end
        end
        StRespond: begin
          l1_ready_q <= 1'b0;
          l1_hit_q   <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cache_io.l1_data_out  = l1_data_out_q;
  assign cache_io.l1_ready     = l1_ready_q;
  assign cache_io.l1_hit       = l1_hit_q;
  assign cache_io.mem_addr     = mem_addr_q;
  assign cache_io.mem_data_out = mem_data_out_q;
  assign cache_io.mem_read     = mem_read_q;
  assign cache_io.mem_write    = mem_write_q;

endmodule
